// File: rtl/as_gpio_irq_ctrl.sv
// as_gpio_irq_ctrl: edge-qualified sticky GPIO interrupt controller with a small register window.
module as_gpio_irq_ctrl #(
  parameter int nr_gpios       = 8,
  parameter int irq_addr_width = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [nr_gpios-1:0]       irq_pulse_i,
  input  logic [nr_gpios-1:0]       level_i,
  input  logic                      en_i,
  input  logic                      we_i,
  input  logic [irq_addr_width-1:0] addr_i,
  input  logic [nr_gpios-1:0]       wdata_i,
  output logic [nr_gpios-1:0]       rdata_o,
  output logic                      ack_o,
  output logic                      irq_o
);
  logic [nr_gpios-1:0] irq_en, rise_en, fall_en, pend, ovr, hit, pclr, oclr, rd;
  logic wr;
  assign wr   = en_i & we_i;
  assign hit  = irq_pulse_i & ((level_i & rise_en) | (~level_i & fall_en));
  assign pclr = (wr && addr_i == irq_addr_width'(3)) ? wdata_i : '0;
  assign oclr = (wr && addr_i == irq_addr_width'(5)) ? wdata_i : '0;
  assign irq_o = |(pend & irq_en);
  always_comb
    rd = addr_i == irq_addr_width'(0) ? irq_en :
         addr_i == irq_addr_width'(1) ? rise_en :
         addr_i == irq_addr_width'(2) ? fall_en :
         addr_i == irq_addr_width'(3) ? pend :
         addr_i == irq_addr_width'(4) ? pend & irq_en :
         addr_i == irq_addr_width'(5) ? ovr : '0;
  always_ff @(posedge clk_i)
    if (!rst_i) begin
      irq_en  <= '0;
      rise_en <= '0;
      fall_en <= '0;
      pend    <= '0;
      ovr     <= '0;
      rdata_o <= '0;
      ack_o   <= 1'b0;
    end else begin
      ack_o <= en_i;
      if (en_i && !we_i) rdata_o <= rd;
      if (wr && addr_i == irq_addr_width'(0)) irq_en <= wdata_i;
      if (wr && addr_i == irq_addr_width'(1)) rise_en <= wdata_i;
      if (wr && addr_i == irq_addr_width'(2)) fall_en <= wdata_i;
      pend <= (pend & ~pclr) | hit;
      ovr  <= (ovr & ~oclr) | (hit & pend & ~pclr);
    end
endmodule

// File: tb/tb_as_gpio_irq_ctrl.sv
// tb_as_gpio_irq_ctrl: directed and random stimulus checked every cycle against a bit-level model.
module tb_as_gpio_irq_ctrl;
  logic clk_i = 0, rst_i = 0, en_i = 0, we_i = 0, ack_o, irq_o;
  logic [2:0] addr_i = 0;
  logic [7:0] irq_pulse_i = 0, level_i = 0, wdata_i = 0, rdata_o;
  int tests = 0, fails = 0;
  logic mvalid = 0, m_ack = 0;
  logic [7:0] m_ien = 0, m_rise = 0, m_fall = 0, m_pend = 0, m_ovr = 0, m_rdata = 0;

  as_gpio_irq_ctrl dut (.clk_i(clk_i), .rst_i(rst_i), .irq_pulse_i(irq_pulse_i), .level_i(level_i),
    .en_i(en_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .ack_o(ack_o), .irq_o(irq_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] reg_val(input logic [2:0] a);
    case (a)
      3'd0: return m_ien;
      3'd1: return m_rise;
      3'd2: return m_fall;
      3'd3: return m_pend;
      3'd4: return m_pend & m_ien;
      3'd5: return m_ovr;
      default: return 8'h00;
    endcase
  endfunction

  // Per-pin event rules returning {next OVR, next PEND}
  function automatic logic [15:0] next_po();
    logic [7:0] np = m_pend, no = m_ovr;
    for (int k = 0; k < 8; k++) begin
      logic q, pc, oc;
      q  = irq_pulse_i[k] && (level_i[k] ? m_rise[k] : m_fall[k]);
      pc = en_i && we_i && addr_i == 3 && wdata_i[k];
      oc = en_i && we_i && addr_i == 5 && wdata_i[k];
      if (oc) no[k] = 0;
      if (pc) np[k] = 0;
      if (q) begin
        if (m_pend[k] && !pc) no[k] = 1;
        np[k] = 1;
      end
    end
    return {no, np};
  endfunction

  always @(posedge clk_i)
    if (!rst_i) begin
      {m_ien, m_rise, m_fall, m_pend, m_ovr, m_rdata} <= '0;
      m_ack <= 0;
      mvalid <= 1;
    end else begin
      m_ack <= en_i;
      if (en_i && !we_i) m_rdata <= reg_val(addr_i);
      if (en_i && we_i && addr_i == 0) m_ien <= wdata_i;
      if (en_i && we_i && addr_i == 1) m_rise <= wdata_i;
      if (en_i && we_i && addr_i == 2) m_fall <= wdata_i;
      {m_ovr, m_pend} <= next_po();
    end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i)
    if (mvalid) begin
      chk("ack", {7'd0, ack_o}, {7'd0, m_ack});
      chk("rdata", rdata_o, m_rdata);
      chk("irq", {7'd0, irq_o}, {7'd0, |(m_pend & m_ien)});
    end

  task automatic step(input logic e, input logic w, input logic [2:0] a, input logic [7:0] d,
                      input logic [7:0] p, input logic [7:0] l);
    en_i = e; we_i = w; addr_i = a; wdata_i = d; irq_pulse_i = p; level_i = l;
    @(posedge clk_i);
    #1;
    en_i = 0; we_i = 0; addr_i = 0; wdata_i = 0; irq_pulse_i = 0; level_i = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(1, 1, a, d, 0, 0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
    step(1, 0, a, 0, 0, 0);
    chk(name, rdata_o, exp);
    chk({name, "_ack"}, {7'd0, ack_o}, 8'h01);
  endtask

  task automatic pulse(input logic [7:0] p, input logic [7:0] l);
    step(0, 0, 0, 0, p, l);
  endtask

  task automatic do_reset();
    rst_i = 0;
    repeat (2) step(1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    chk("rst_ack", {7'd0, ack_o}, 8'h00);
    chk("rst_rdata", rdata_o, 8'h00);
    chk("rst_irq", {7'd0, irq_o}, 8'h00);
    rst_i = 1;
  endtask

  initial begin
    do_reset();
    for (int a = 0; a < 6; a++) rd(3'(a), 8'h00, "rst_reg");
    wr(0, 8'h01); wr(1, 8'h01);
    pulse(8'h01, 8'h01);
    chk("rise_irq", {7'd0, irq_o}, 8'h01);
    rd(3, 8'h01, "rise_pend");
    do_reset();
    wr(0, 8'h01); wr(1, 8'h01);
    pulse(8'h01, 8'h00);
    chk("fall_ignored_irq", {7'd0, irq_o}, 8'h00);
    rd(3, 8'h00, "fall_ignored_pend");
    do_reset();
    wr(1, 8'hFF); wr(0, 8'h00);
    pulse(8'h08, 8'h08);
    chk("masked_irq", {7'd0, irq_o}, 8'h00);
    rd(3, 8'h08, "masked_pend");
    rd(4, 8'h00, "masked_status");
    wr(0, 8'h08);
    chk("unmask_irq", {7'd0, irq_o}, 8'h01);
    pulse(8'h08, 8'h08);
    rd(5, 8'h08, "ovr_set");
    wr(3, 8'h08);
    chk("w1c_irq", {7'd0, irq_o}, 8'h00);
    rd(3, 8'h00, "w1c_pend");
    wr(5, 8'h08);
    rd(5, 8'h00, "ovr_clr");
    pulse(8'h04, 8'h04);
    step(1, 1, 3, 8'h04, 8'h04, 8'h04);
    rd(3, 8'h04, "simul_pend");
    rd(5, 8'h00, "simul_ovr");
    wr(6, 8'hFF);
    rd(6, 8'h00, "unmapped");
    rd(0, 8'h08, "b2b_ien");
    rd(1, 8'hFF, "b2b_rise");
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(99) != 0);
      en_i = 1'($urandom); we_i = 1'($urandom); addr_i = 3'($urandom);
      wdata_i = 8'($urandom); irq_pulse_i = 8'($urandom) & 8'($urandom); level_i = 8'($urandom);
      @(posedge clk_i);
      #1;
    end
    rst_i = 1; en_i = 0; irq_pulse_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
